clmul128_seq: RTL and testbench



---
 rtl/clmul128_seq.sv | 158 +++++++++++++++
 tb/tb_clmul128_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clmul128_seq.sv
// Sequential 128x128 carry-less multiplier: Karatsuba over one shared 64x64 core.
// Define CLMUL128_REDUCE_EN to add a REDUCE state returning the GF(2^128) residue.
module clmul128_seq (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] a,
   input  logic [127:0] b,
   output logic         ready,
   output logic         done,
   output logic [255:0] prod
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_LO,
      S_MUL_HI,
      S_MUL_MID,
`ifdef CLMUL128_REDUCE_EN
      S_COMBINE,
      S_REDUCE
`else
      S_COMBINE
`endif
   } state_t;

   state_t         state_q;
   logic           ready_q;
   logic           done_q;
   logic [126:0]   lo_q;
   logic [126:0]   hi_q;
   logic [126:0]   mid_q;
   logic [255:0]   prod_q;
   logic [127:0]   a_q;
   logic [127:0]   b_q;
   logic [63:0]    mul_x;
   logic [63:0]    mul_y;
   logic [126:0]   mul_r;
   logic [126:0]   mid_x;
   logic [254:0]   p_d;
`ifdef CLMUL128_REDUCE_EN
   logic [254:0]   p_q;
`endif

   function automatic logic [126:0] clmul64(input logic [63:0] x, input logic [63:0] y);
      logic [126:0] acc;
      acc = '0;
      for (int i = 0; i < 64; i++) begin
         if (y[i]) acc = acc ^ ({63'b0, x} << i);
      end
      return acc;
   endfunction

`ifdef CLMUL128_REDUCE_EN
   // x^128 == x^7+x^2+x+1; the first fold spills up to bit 133, the second cannot.
   function automatic logic [127:0] gf128_reduce(input logic [254:0] p);
      logic [133:0] h;
      logic [133:0] f1;
      logic [12:0]  g;
      logic [12:0]  f2;
      h  = {7'b0, p[254:128]};
      f1 = h ^ (h << 1) ^ (h << 2) ^ (h << 7);
      g  = {7'b0, f1[133:128]};
      f2 = g ^ (g << 1) ^ (g << 2) ^ (g << 7);
      return p[127:0] ^ f1[127:0] ^ {115'b0, f2};
   endfunction
`endif

   always_comb begin
      mul_x = a_q[63:0];
      mul_y = b_q[63:0];
      case (state_q)
         S_MUL_HI: begin
            mul_x = a_q[127:64];
            mul_y = b_q[127:64];
         end
         S_MUL_MID: begin
            mul_x = a_q[63:0] ^ a_q[127:64];
            mul_y = b_q[63:0] ^ b_q[127:64];
         end
         default: ;
      endcase
   end

   assign mul_r = clmul64(mul_x, mul_y);
   assign mid_x = mid_q ^ lo_q ^ hi_q;
   assign p_d   = {hi_q, 128'b0} ^ {64'b0, mid_x, 64'b0} ^ {128'b0, lo_q};

   // Operand and product staging carry no reset; they are qualified by the FSM.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && start) begin
         a_q <= a;
         b_q <= b;
      end
`ifdef CLMUL128_REDUCE_EN
      if (state_q == S_COMBINE) p_q <= p_d;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         lo_q    <= '0;
         hi_q    <= '0;
         mid_q   <= '0;
         prod_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_MUL_LO;
                  ready_q <= 1'b0;
               end
            end
            S_MUL_LO: begin
               lo_q    <= mul_r;
               state_q <= S_MUL_HI;
            end
            S_MUL_HI: begin
               hi_q    <= mul_r;
               state_q <= S_MUL_MID;
            end
            S_MUL_MID: begin
               mid_q   <= mul_r;
               state_q <= S_COMBINE;
            end
`ifdef CLMUL128_REDUCE_EN
            S_COMBINE: state_q <= S_REDUCE;
            S_REDUCE: begin
               prod_q  <= {128'b0, gf128_reduce(p_q)};
               done_q  <= 1'b1;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
`else
            S_COMBINE: begin
               prod_q  <= {1'b0, p_d};
               done_q  <= 1'b1;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
`endif
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ready = ready_q;
   assign done  = done_q;
   assign prod  = prod_q;

endmodule

// File: tb/tb_clmul128_seq.sv
// Directed bench for clmul128_seq; expectations follow CLMUL128_REDUCE_EN.
module tb_clmul128_seq;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] a;
   logic [127:0] b;
   logic         ready;
   logic         done;
   logic [255:0] prod;

   int n_checks = 0;
   int n_errors = 0;

`ifdef CLMUL128_REDUCE_EN
   localparam int LAT = 5;
   localparam bit RED = 1'b1;
`else
   localparam int LAT = 4;
   localparam bit RED = 1'b0;
`endif

   typedef struct {
      logic [127:0] a;
      logic [127:0] b;
      logic [255:0] exp;
   } vec_t;

   vec_t vt[7];

   clmul128_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .ready (ready),
      .done  (done),
      .prod  (prod)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [255:0] pick(input logic [255:0] raw, input logic [255:0] red);
      return RED ? red : raw;
   endfunction

   task automatic run_txn(input logic [127:0] ta, input logic [127:0] tb_v,
                          output logic [255:0] got, output int lat);
      @(negedge clk);
      a = ta;
      b = tb_v;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!done && lat < 20);
      got = prod;
   endtask

   logic [255:0] got;
   logic [255:0] held;
   int           lat;
   int           n_done;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;

      vt[0] = '{128'h1, 128'h1, 256'h1};
      vt[1] = '{128'h3, 128'h3, 256'h5};
      vt[2] = '{(128'b1 << 64) | 128'h1, (128'b1 << 64) | 128'h1,
                pick((256'b1 << 128) | 256'h1, 256'h86)};
      vt[3] = '{128'b1 << 127, 128'h2, pick(256'b1 << 128, 256'h87)};
      vt[4] = '{128'b1 << 127, 128'b1 << 127,
                pick(256'b1 << 254, {128'b0, 128'hC000_0000_0000_0000_0000_0000_0000_1067})};
      vt[5] = '{128'hFFFF_FFFF_FFFF_FFFF, 128'b1 << 64,
                256'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000};
      vt[6] = '{(128'b1 << 100) | (128'b1 << 3), (128'b1 << 50) | 128'h2,
                pick((256'b1 << 150) | (256'b1 << 101) | (256'b1 << 53) | (256'b1 << 4),
                     (256'b1 << 101) | (256'b1 << 53) | (256'b1 << 29) | (256'b1 << 24)
                     | (256'b1 << 23) | (256'b1 << 22) | (256'b1 << 4))};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", 256'(ready), 256'd1);
      chk("reset_done", 256'(done), 256'd0);
      chk("reset_prod", prod, 256'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_txn(vt[i].a, vt[i].b, got, lat);
         chk($sformatf("vec%0d_latency", i), 256'(lat), 256'(LAT));
         chk($sformatf("vec%0d_prod", i), got, vt[i].exp);
      end

      // prod must hold and done must be a single-cycle pulse
      held = prod;
      repeat (3) @(posedge clk);
      #1;
      chk("hold_prod", prod, vt[6].exp);
      chk("done_pulse", 256'(done), 256'd0);

      // start held high through the whole busy window, then back-to-back
      @(negedge clk);
      a = vt[2].a;
      b = vt[2].b;
      start = 1'b1;
      @(posedge clk);
      #1;
      a = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
      b = 128'h1357_9BDF_2468_ACE0_0F0F_F0F0_3C3C_C3C3;
      n_done = 0;
      for (int c = 1; c < LAT; c++) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
         chk($sformatf("busy_ready_c%0d", c), 256'(ready), 256'd0);
      end
      @(posedge clk);
      #1;
      if (done) n_done++;
      chk("busy_one_done", 256'(n_done), 256'd1);
      chk("busy_ready_back", 256'(ready), 256'd1);
      chk("busy_prod", prod, vt[2].exp);
      a = vt[3].a;
      b = vt[3].b;
      @(posedge clk);
      #1 start = 1'b0;
      chk("b2b_accepted", 256'(ready), 256'd0);
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!done && lat < 20);
      chk("b2b_latency", 256'(lat), 256'(LAT));
      chk("b2b_prod", prod, vt[3].exp);

      // asynchronous reset while in MUL_HI
      @(negedge clk);
      a = vt[6].a;
      b = vt[6].b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_prod", prod, 256'd0);
      chk("abort_ready", 256'(ready), 256'd1);
      chk("abort_done", 256'(done), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      repeat (8) begin
         @(posedge clk);
         #1 if (done) n_done++;
      end
      chk("abort_no_done", 256'(n_done), 256'd0);
      chk("abort_prod_stays", prod, 256'd0);

      run_txn(vt[4].a, vt[4].b, got, lat);
      chk("post_abort_latency", 256'(lat), 256'(LAT));
      chk("post_abort_prod", got, vt[4].exp);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
